// File: rtl/issue_stage_if.sv
// Bundle of decode, pending-register-table and execution-unit signals around the issue slot.
// The master side is the issue stage itself; the slave side is its surrounding pipeline.
interface issue_stage_if #(
  parameter int PAYLOAD_W = 64
);
  logic                 in_valid;
  logic                 in_ready;
  logic [5:0]           in_rs1;
  logic [5:0]           in_rs2;
  logic [5:0]           in_rd;
  logic                 in_rs1_used;
  logic                 in_rs2_used;
  logic                 in_rd_used;
  logic                 in_unit;
  logic [PAYLOAD_W-1:0] in_payload;
  logic                 flush;
  logic [63:0]          reg_busy;
  logic [5:0]           busy_rn;
  logic                 busy_en;
  logic                 ex0_valid;
  logic                 ex1_valid;
  logic                 ex0_ready;
  logic                 ex1_ready;
  logic [PAYLOAD_W-1:0] ex_payload;
  logic [5:0]           ex_rd;
  logic [31:0]          stall_cycles;

  modport master (
    input  in_valid, in_rs1, in_rs2, in_rd, in_rs1_used, in_rs2_used, in_rd_used,
           in_unit, in_payload, flush, reg_busy, ex0_ready, ex1_ready,
    output in_ready, busy_rn, busy_en, ex0_valid, ex1_valid, ex_payload, ex_rd,
           stall_cycles
  );

  modport slave (
    output in_valid, in_rs1, in_rs2, in_rd, in_rs1_used, in_rs2_used, in_rd_used,
           in_unit, in_payload, flush, reg_busy, ex0_ready, ex1_ready,
    input  in_ready, busy_rn, busy_en, ex0_valid, ex1_valid, ex_payload, ex_rd,
           stall_cycles
  );
endinterface

// File: rtl/issue_stage.sv
// Single-slot in-order issue stage: holds one decoded instruction, blocks on RAW/WAW
// hazards against the pending register table, and marks the destination busy on dispatch.
module issue_stage #(
  parameter int PAYLOAD_W = 64
) (
  input  logic          clk,
  input  logic          rst,
  issue_stage_if.master bus
);
  typedef enum logic {EMPTY, HELD} state_t;

  state_t               state_reg, state_next;
  logic [5:0]           rs1_reg, rs2_reg, rd_reg;
  logic                 rs1_used_reg, rs2_used_reg, unit_reg;
  logic [PAYLOAD_W-1:0] payload_reg;
  logic [31:0]          stall_reg;

  logic slot_valid, hazard, offer, ex0_valid_int, ex1_valid_int, fire, in_ready_int, capture;

  assign slot_valid = (state_reg == HELD);

  // rd is stored as 0 when unused, so a zero rd never produces a WAW hazard
  always_comb begin
    hazard = (rs1_used_reg && (rs1_reg != 6'd0) && bus.reg_busy[rs1_reg]) ||
             (rs2_used_reg && (rs2_reg != 6'd0) && bus.reg_busy[rs2_reg]) ||
             ((rd_reg != 6'd0) && bus.reg_busy[rd_reg]);
    offer         = slot_valid && !hazard && !bus.flush;
    ex0_valid_int = offer && !unit_reg;
    ex1_valid_int = offer && unit_reg;
    fire          = (ex0_valid_int && bus.ex0_ready) || (ex1_valid_int && bus.ex1_ready);
    in_ready_int  = !bus.flush && (!slot_valid || fire);
    capture       = bus.in_valid && in_ready_int;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY: if (capture) state_next = HELD;
      HELD: begin
        if (bus.flush)            state_next = EMPTY;
        else if (fire && !capture) state_next = EMPTY;
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= EMPTY;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs1_reg      <= '0;
      rs2_reg      <= '0;
      rd_reg       <= '0;
      rs1_used_reg <= 1'b0;
      rs2_used_reg <= 1'b0;
      unit_reg     <= 1'b0;
      payload_reg  <= '0;
    end else if (capture) begin
      rs1_reg      <= bus.in_rs1;
      rs2_reg      <= bus.in_rs2;
      rd_reg       <= bus.in_rd_used ? bus.in_rd : 6'd0;
      rs1_used_reg <= bus.in_rs1_used;
      rs2_used_reg <= bus.in_rs2_used;
      unit_reg     <= bus.in_unit;
      payload_reg  <= bus.in_payload;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_reg <= '0;
    else if (slot_valid && !fire && !bus.flush && (stall_reg != 32'hFFFF_FFFF))
      stall_reg <= stall_reg + 32'd1;
  end

  assign bus.in_ready     = in_ready_int;
  assign bus.ex0_valid    = ex0_valid_int;
  assign bus.ex1_valid    = ex1_valid_int;
  assign bus.busy_en      = fire && (rd_reg != 6'd0);
  assign bus.busy_rn      = fire ? rd_reg : 6'd0;
  assign bus.ex_payload   = slot_valid ? payload_reg : '0;
  assign bus.ex_rd        = slot_valid ? rd_reg : 6'd0;
  assign bus.stall_cycles = stall_reg;
endmodule

// File: tb/tb_issue_stage.sv
// Randomized and directed bench for issue_stage, checked cycle by cycle against a
// behavioural slot model derived from the hazard/dispatch rules.
module tb_issue_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  issue_stage_if #(.PAYLOAD_W(64)) bus ();

  issue_stage #(.PAYLOAD_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  // behavioural model of the slot
  bit          m_valid;
  logic [5:0]  m_rs1, m_rs2, m_rd;
  bit          m_rs1u, m_rs2u, m_unit;
  logic [63:0] m_payload;
  longint      m_stall;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
    m_rs1u = 0; m_rs2u = 0; m_unit = 0; m_payload = 0; m_stall = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, ".in_ready"},  bus.in_ready, 1);
    check_val({tag, ".ex0_valid"}, bus.ex0_valid, 0);
    check_val({tag, ".ex1_valid"}, bus.ex1_valid, 0);
    check_val({tag, ".busy_en"},   bus.busy_en, 0);
    check_val({tag, ".busy_rn"},   bus.busy_rn, 0);
    check_val({tag, ".ex_payload"}, bus.ex_payload, 0);
    check_val({tag, ".ex_rd"},     bus.ex_rd, 0);
    check_val({tag, ".stall"},     bus.stall_cycles, 0);
  endtask

  task automatic set_instr(input bit v, input logic [5:0] rs1, input bit rs1u,
                           input logic [5:0] rs2, input bit rs2u,
                           input logic [5:0] rd, input bit rdu, input bit unit);
    bus.in_valid = v;
    bus.in_rs1 = rs1; bus.in_rs1_used = rs1u;
    bus.in_rs2 = rs2; bus.in_rs2_used = rs2u;
    bus.in_rd = rd;   bus.in_rd_used = rdu;
    bus.in_unit = unit;
    bus.in_payload = {$urandom, $urandom};
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic do_cycle();
    bit haz, offer, fire, exp_in_ready, cap;
    #2;
    haz = m_valid && ((m_rs1u && m_rs1 != 0 && bus.reg_busy[m_rs1]) ||
                      (m_rs2u && m_rs2 != 0 && bus.reg_busy[m_rs2]) ||
                      (m_rd != 0 && bus.reg_busy[m_rd]));
    offer = m_valid && !haz && !bus.flush;
    fire = offer && (m_unit ? bus.ex1_ready : bus.ex0_ready);
    exp_in_ready = !bus.flush && (!m_valid || fire);
    check_val("in_ready",   bus.in_ready, exp_in_ready);
    check_val("ex0_valid",  bus.ex0_valid, offer && !m_unit);
    check_val("ex1_valid",  bus.ex1_valid, offer && m_unit);
    check_val("busy_en",    bus.busy_en, fire && m_rd != 0);
    check_val("busy_rn",    bus.busy_rn, fire ? m_rd : 6'd0);
    check_val("ex_payload", bus.ex_payload, m_valid ? m_payload : 64'd0);
    check_val("ex_rd",      bus.ex_rd, m_valid ? m_rd : 6'd0);
    check_val("stall",      bus.stall_cycles, m_stall);
    if (fire)
      $display("dispatch unit=%0d rd=%0d payload=%h stall=%0d", m_unit, m_rd, m_payload, m_stall);
    cap = bus.in_valid && exp_in_ready;
    @(posedge clk);
    if (m_valid && !fire && !bus.flush && m_stall < 64'hFFFF_FFFF) m_stall++;
    if (bus.flush) m_valid = 0;
    else if (cap) begin
      m_valid = 1;
      m_rs1 = bus.in_rs1; m_rs1u = bus.in_rs1_used;
      m_rs2 = bus.in_rs2; m_rs2u = bus.in_rs2_used;
      m_rd = bus.in_rd_used ? bus.in_rd : 6'd0;
      m_unit = bus.in_unit; m_payload = bus.in_payload;
    end else if (fire) m_valid = 0;
    @(negedge clk);
  endtask

  task automatic mid_reset(input string tag);
    bus.flush = 0;
    #2 rst = 1'b1;
    #1 check_reset_outputs(tag);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_clear();
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
    bus.flush = 0; bus.reg_busy = '0; bus.ex0_ready = 0; bus.ex1_ready = 0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // rd=5 to unit 0, free table
    bus.ex0_ready = 1;
    set_instr(1, 0, 0, 0, 0, 6'd5, 1, 0); do_cycle();
    bus.in_valid = 0; do_cycle(); do_cycle();

    // RAW on r3 for four cycles, then release
    bus.reg_busy = 64'h8;
    set_instr(1, 6'd3, 1, 0, 0, 6'd9, 1, 0); do_cycle();
    bus.in_valid = 0; repeat (4) do_cycle();
    bus.reg_busy = '0; do_cycle(); do_cycle();

    // r0 source never hazards
    bus.reg_busy = ~64'h1;
    set_instr(1, 6'd0, 1, 0, 0, 6'd0, 0, 0); do_cycle();
    bus.in_valid = 0; do_cycle();
    bus.reg_busy = '0;

    // unit 1 back-pressure, then fire with simultaneous capture
    bus.ex1_ready = 0;
    set_instr(1, 6'd1, 1, 6'd2, 1, 6'd7, 1, 1); do_cycle();
    bus.in_valid = 0; repeat (3) do_cycle();
    bus.ex1_ready = 1;
    set_instr(1, 0, 0, 0, 0, 6'd8, 1, 0); do_cycle();
    bus.in_valid = 0; do_cycle();

    // flush while held and ready
    set_instr(1, 0, 0, 0, 0, 6'd4, 1, 0); do_cycle();
    bus.in_valid = 1; bus.flush = 1; do_cycle();
    bus.in_valid = 0; bus.flush = 0; do_cycle();

    // reset while holding
    bus.ex0_ready = 0;
    set_instr(1, 0, 0, 0, 0, 6'd6, 1, 0); do_cycle();
    bus.in_valid = 0; do_cycle();
    mid_reset("midreset");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      set_instr($urandom_range(0, 99) < 60, 6'($urandom_range(0, 7)), 1'($urandom),
                6'($urandom_range(0, 7)), 1'($urandom), 6'($urandom_range(0, 7)),
                1'($urandom), 1'($urandom));
      bus.reg_busy = {56'd0, 8'($urandom & $urandom)};
      bus.ex0_ready = $urandom_range(0, 99) < 70;
      bus.ex1_ready = $urandom_range(0, 99) < 70;
      bus.flush = $urandom_range(0, 99) < 5;
      if (i == 250 || i == 450) mid_reset("rand_reset");
      else do_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
